// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared encodings for the snake game blocks: game and collision
//               state codes, score FSM states, seven-segment map and a
//               saturating 3-digit BCD increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  // Game FSM encodings driven by the top-level game controller
  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] PLAY      = 2'b01;
  localparam logic [1:0] GAME_OVER = 2'b11;

  // Collision detector encodings
  localparam logic [1:0] COLLISION       = 2'b01;
  localparam logic [1:0] APPLE_COLLECTED = 2'b10;

  // Digit cell geometry in pixels
  localparam int DIGIT_W = 12;
  localparam int DIGIT_H = 20;

  // Segment bit order: [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Score keeper FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } score_state_t;

  // Map a BCD digit to its lit segments; non-decimal codes are blank
  function automatic logic [6:0] seg_map(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Add one to a 3-digit BCD value, rippling carries; 999 holds at 999
  function automatic logic [11:0] bcd_inc(input logic [11:0] value);
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    units    = value[3:0];
    tens     = value[7:4];
    hundreds = value[11:8];
    if (value == 12'h999) begin
      return value;
    end
    if (units == 4'd9) begin
      units = 4'd0;
      if (tens == 4'd9) begin
        tens     = 4'd0;
        hundreds = hundreds + 4'd1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      units = units + 4'd1;
    end
    return {hundreds, tens, units};
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_digit.sv
`default_nettype none
// ============================================================================
// Module      : score_digit
// Description : Combinational seven-segment pixel test for one 12x20 digit
//               cell. lx/ly are cell-local coordinates already range checked
//               by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module score_digit
  import snake_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [3:0] lx,
  input  logic [4:0] ly,
  output logic       lit
);

  logic [6:0] w_seg;
  logic       w_left;
  logic       w_right;
  logic       w_upper;
  logic       w_lower;
  logic       w_on_a;
  logic       w_on_b;
  logic       w_on_c;
  logic       w_on_d;
  logic       w_on_e;
  logic       w_on_f;
  logic       w_on_g;

  assign w_seg   = seg_map(digit);

  // Vertical strokes are 2 px wide at each edge; the halves overlap on the g band
  assign w_left  = (lx <= 4'd1);
  assign w_right = (lx >= 4'd10);
  assign w_upper = (ly <= 5'd10);
  assign w_lower = (ly >= 5'd9);

  assign w_on_a  = w_seg[6] && (ly <= 5'd1);
  assign w_on_b  = w_seg[5] && w_right && w_upper;
  assign w_on_c  = w_seg[4] && w_right && w_lower;
  assign w_on_d  = w_seg[3] && (ly >= 5'd18);
  assign w_on_e  = w_seg[2] && w_left && w_lower;
  assign w_on_f  = w_seg[1] && w_left && w_upper;
  assign w_on_g  = w_seg[0] && (ly >= 5'd9) && (ly <= 5'd10);

  assign lit = w_on_a | w_on_b | w_on_c | w_on_d | w_on_e | w_on_f | w_on_g;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Keeps a 3-digit BCD score and high score driven by the game
//               FSM and collision detector, and draws the score as three
//               seven-segment digits in the top-right of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
  import snake_pkg::*;
#(
  parameter int         BIT         = 10,
  parameter int         X_START     = 560,
  parameter int         Y_START     = 8,
  parameter int         DIGIT_PITCH = 16,
  parameter logic [2:0] SCORE_RGB   = 3'b110
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     game_state,
  input  logic [1:0]     collision_state,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  output logic [11:0]    score,
  output logic [11:0]    high_score,
  output logic           score_active,
  output logic [2:0]     rgb
);

  score_state_t r_state;
  logic [11:0]  r_score;
  logic [11:0]  r_high;
  logic [1:0]   r_prev_game;
  logic [1:0]   r_prev_collision;
  logic         w_inc;
  logic         w_play_edge;
  logic [2:0]   w_cell_lit;

  // One-cycle history of both status inputs for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_game      <= IDLE;
      r_prev_collision <= 2'b00;
    end else begin
      r_prev_game      <= game_state;
      r_prev_collision <= collision_state;
    end
  end

  // A held APPLE_COLLECTED only counts on its first cycle
  assign w_inc       = (collision_state == APPLE_COLLECTED) &&
                       (r_prev_collision != APPLE_COLLECTED);
  assign w_play_edge = (game_state == PLAY) && (r_prev_game != PLAY);

  // Score FSM: clear on game start, count apples while running, latch best on game over
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_score <= 12'h000;
      r_high  <= 12'h000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_play_edge) begin
            r_score <= 12'h000;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // The increment lands even on the game-over cycle so S_OVER sees it
          if (w_inc) begin
            r_score <= bcd_inc(r_score);
          end
          if (game_state == GAME_OVER) begin
            r_state <= S_OVER;
          end else if (game_state == IDLE) begin
            r_state <= S_IDLE;
          end
        end
        S_OVER: begin
          // Packed BCD orders the same as binary, so a plain compare suffices
          if (r_score > r_high) begin
            r_high <= r_score;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score      = r_score;
  assign high_score = r_high;

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    localparam logic [BIT-1:0] c_x0 = BIT'(X_START + gi * DIGIT_PITCH);
    localparam logic [BIT-1:0] c_y0 = BIT'(Y_START);

    logic       w_in_cell;
    logic [3:0] w_lx;
    logic [4:0] w_ly;
    logic       w_lit;

    assign w_in_cell = (x_pos >= c_x0) && (x_pos < c_x0 + BIT'(DIGIT_W)) &&
                       (y_pos >= c_y0) && (y_pos < c_y0 + BIT'(DIGIT_H));

    // Subtract only once inside the cell so no wrapped offset can alias in
    assign w_lx = w_in_cell ? 4'(x_pos - c_x0) : 4'd0;
    assign w_ly = w_in_cell ? 5'(y_pos - c_y0) : 5'd0;

    score_digit u_digit (
      .digit (r_score[11-4*gi -: 4]),
      .lx    (w_lx),
      .ly    (w_ly),
      .lit   (w_lit)
    );

    assign w_cell_lit[gi] = w_in_cell && w_lit;
  end

  assign score_active = |w_cell_lit;
  assign rgb          = score_active ? SCORE_RGB : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Directed self-checking bench for score_keeper: reset, apple
//               edge counting, BCD carries and saturation, high score capture
//               and digit rendering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  localparam int         BIT         = 10;
  localparam int         X_START     = 560;
  localparam int         Y_START     = 8;
  localparam int         DIGIT_PITCH = 16;
  localparam logic [2:0] SCORE_RGB   = 3'b110;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     game_state;
  logic [1:0]     collision_state;
  logic [BIT-1:0] x_pos;
  logic [BIT-1:0] y_pos;
  logic [11:0]    score;
  logic [11:0]    high_score;
  logic           score_active;
  logic [2:0]     rgb;

  int checks = 0;
  int errors = 0;

  score_keeper #(
    .BIT         (BIT),
    .X_START     (X_START),
    .Y_START     (Y_START),
    .DIGIT_PITCH (DIGIT_PITCH),
    .SCORE_RGB   (SCORE_RGB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .game_state      (game_state),
    .collision_state (collision_state),
    .x_pos           (x_pos),
    .y_pos           (y_pos),
    .score           (score),
    .high_score      (high_score),
    .score_active    (score_active),
    .rgb             (rgb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apple(input int hold);
    collision_state = 2'b10;
    tick(hold);
    collision_state = 2'b00;
    tick(1);
  endtask

  task automatic apples(input int n);
    repeat (n) apple(1);
  endtask

  task automatic new_game();
    game_state = 2'b00;
    tick(1);
    game_state = 2'b01;
    tick(2);
  endtask

  task automatic end_game();
    game_state = 2'b11;
    tick(1);
    game_state = 2'b00;
    tick(1);
  endtask

  task automatic pixel(input string tag, input int x, input int y, input logic exp_active);
    x_pos = BIT'(x);
    y_pos = BIT'(y);
    #1;
    check_eq({tag, "_active"}, score_active, exp_active);
    check_eq({tag, "_rgb"}, rgb, exp_active ? SCORE_RGB : 3'b000);
  endtask

  initial begin
    reset           = 1'b0;
    game_state      = 2'b00;
    collision_state = 2'b00;
    x_pos           = '0;
    y_pos           = '0;
    tick(3);
    check_eq("rst_score", score, 12'h000);
    check_eq("rst_high", high_score, 12'h000);
    pixel("rst_pix_a0", X_START, Y_START, 1'b1);
    reset = 1'b1;
    tick(1);

    // Asynchronous reset in the middle of a running game
    new_game();
    apples(42);
    check_eq("pre_rst_042", score, 12'h042);
    reset = 1'b0;
    #1;
    check_eq("async_rst_score", score, 12'h000);
    check_eq("async_rst_high", high_score, 12'h000);
    pixel("async_rst_pix", X_START, Y_START, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(1);

    // Held collision counts once per collection
    new_game();
    check_eq("start_000", score, 12'h000);
    apple(5);
    check_eq("hold_once", score, 12'h001);
    apple(5);
    apple(5);
    check_eq("three_apples", score, 12'h003);

    // BCD carries and saturation
    apples(6);
    check_eq("at_009", score, 12'h009);
    apple(1);
    check_eq("carry_010", score, 12'h010);
    apples(89);
    check_eq("at_099", score, 12'h099);
    apple(1);
    check_eq("carry_100", score, 12'h100);
    apples(899);
    check_eq("at_999", score, 12'h999);
    apple(1);
    check_eq("sat_999", score, 12'h999);

    // Abort without GAME_OVER leaves high score alone and keeps score shown
    game_state = 2'b00;
    tick(2);
    check_eq("abort_high", high_score, 12'h000);
    check_eq("abort_score_held", score, 12'h999);

    // High score capture and hold
    new_game();
    check_eq("restart_clear", score, 12'h000);
    apples(7);
    check_eq("at_007", score, 12'h007);
    game_state = 2'b11;
    tick(1);
    check_eq("high_lat1", high_score, 12'h000);
    game_state = 2'b00;
    tick(1);
    check_eq("high_007", high_score, 12'h007);
    new_game();
    apples(5);
    end_game();
    check_eq("high_keep_007", high_score, 12'h007);
    tick(3);
    check_eq("idle_shows_005", score, 12'h005);

    // Apple and GAME_OVER in the same cycle
    new_game();
    apples(6);
    check_eq("at_006", score, 12'h006);
    collision_state = 2'b10;
    game_state      = 2'b11;
    tick(1);
    check_eq("sim_score_007", score, 12'h007);
    collision_state = 2'b00;
    game_state      = 2'b00;
    tick(1);
    check_eq("sim_high_007", high_score, 12'h007);
    new_game();
    apples(7);
    collision_state = 2'b10;
    game_state      = 2'b11;
    tick(1);
    collision_state = 2'b00;
    game_state      = 2'b00;
    tick(1);
    check_eq("sim_score_008", score, 12'h008);
    check_eq("sim_high_008", high_score, 12'h008);

    // Rendering of 120
    new_game();
    apples(120);
    check_eq("at_120", score, 12'h120);
    pixel("seg_b_of_2", X_START + DIGIT_PITCH + 10, Y_START + 5, 1'b1);
    pixel("seg_c_of_2", X_START + DIGIT_PITCH + 10, Y_START + 14, 1'b0);
    pixel("cell_gap", X_START + 12, Y_START, 1'b0);
    pixel("seg_a_of_1", X_START, Y_START, 1'b0);
    pixel("seg_b_of_1", X_START + 10, Y_START + 2, 1'b1);
    pixel("seg_d_of_0", X_START + 2 * DIGIT_PITCH + 5, Y_START + 19, 1'b1);
    pixel("below_cell", X_START + 10, Y_START + 20, 1'b0);
    pixel("origin", 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
